tt_um_serial_sub: RTL and testbench



---
 rtl/tt_um_serial_sub_if.sv | 20 ++
 rtl/tt_um_serial_sub.sv | 114 +++++++++++
 tb/tb_tt_um_serial_sub.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_serial_sub_if.sv
// Tile pin bundle for the serial subtractor.
// master drives the inputs, slave is the design side.
interface tt_um_serial_sub_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/tt_um_serial_sub.sv
// Bit-serial subtractor (A - B, LSB first) on the tile pin wrapper.
// Optional macro SUB_ZERO_FLAG_EN adds a registered zero-result flag.
module tt_um_serial_sub #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   tt_um_serial_sub_if.slave pins
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             brw;
   logic [WIDTH-1:0] res;
   logic             d_bit;
   logic             d_valid;
   logic             zero;

   logic             a;
   logic             b;
   logic             start;
   logic             bit_valid;
   logic             d;
   logic             brw_nx;
   logic [WIDTH:0]   sh;
   logic             last;
   logic             take;
   logic             busy;
   logic             done;
   logic             unused;

   assign a         = pins.ui_in[0];
   assign b         = pins.ui_in[1];
   assign start     = pins.ui_in[2];
   assign bit_valid = pins.ui_in[3];

   assign unused = &{1'b0, pins.ena, pins.ui_in[7:4], pins.uio_in};

   // Difference/borrow for the current bit pair and the shifted result.
   always_comb begin
      d      = a ^ b ^ brw;
      brw_nx = (~a & b) | (~(a ^ b) & brw);
      sh     = {d, res};
      last   = (cnt == CW'(WIDTH - 1));
      take   = (state == RUN) && bit_valid && !start;
   end

   // Main FSM: start always restarts a clean run; bits only count in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         brw     <= 1'b0;
         res     <= '0;
         d_bit   <= 1'b0;
         d_valid <= 1'b0;
      end else begin
         d_valid <= 1'b0;
         if (start) begin
            state <= RUN;
            cnt   <= '0;
            brw   <= 1'b0;
            res   <= '0;
         end else if (take) begin
            d_bit   <= d;
            d_valid <= 1'b1;
            brw     <= brw_nx;
            res     <= sh[WIDTH:1];
            cnt     <= cnt + CW'(1);
            if (last) begin
               state <= DONE;
            end
         end
      end
   end

`ifdef SUB_ZERO_FLAG_EN
   // Zero flag captured on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
      end else if (start) begin
         zero <= 1'b0;
      end else if (take && last) begin
         zero <= (sh[WIDTH:1] == '0);
      end
   end
`else
   assign zero = 1'b0;
`endif

   assign busy = (state == RUN);
   assign done = (state == DONE);

   assign pins.uo_out = {
      2'b00,
      busy,
      zero & done,
      brw & (state != IDLE),
      done,
      d_valid,
      d_bit
   };

   assign pins.uio_out = done ? 8'(res) : 8'h00;
   assign pins.uio_oe  = {8{done}};

endmodule

// File: tb/tb_tt_um_serial_sub.sv
// Self-checking bench for tt_um_serial_sub: vector table,
// hand sequences (abort, async reset) and randomized runs.
module tb_tt_um_serial_sub;

   localparam int W = 8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] diff;
      logic       brw;
      int         gap_at;
      int         gap_len;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a_i = 1'b0;
   logic b_i = 1'b0;
   logic st_i = 1'b0;
   logic bv_i = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tt_um_serial_sub_if pins ();

   assign pins.ui_in  = {4'h0, bv_i, st_i, b_i, a_i};
   assign pins.uio_in = 8'h00;
   assign pins.ena    = 1'b1;

   tt_um_serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pins  (pins)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Borrow out of the low n bits: set iff low-n(A) < low-n(B).
   function automatic logic pre_brw(input logic [7:0] a,
                                    input logic [7:0] b, input int n);
      int m;
      m = (1 << n) - 1;
      return ((int'(a) & m) < (int'(b) & m));
   endfunction

   // Start strobe, then W bits (optional idle gap before bit gap_at).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input int gap_at, input int gap_len,
                         input logic bv_on_start, output int cyc);
      logic [7:0] diff;
      logic       fb;
      logic       ez;
      diff = a - b;
      fb   = (a < b);
`ifdef SUB_ZERO_FLAG_EN
      ez = (diff == 8'h00);
`else
      ez = 1'b0;
`endif
      cyc = 0;
      @(negedge clk);
      st_i = 1'b1;
      bv_i = bv_on_start;
      a_i  = 1'($urandom);
      b_i  = 1'($urandom);
      @(negedge clk);
      cyc++;
      st_i = 1'b0;
      chk("start_dv", 32'(pins.uo_out[1]), 32'd0);
      chk("start_busy", 32'(pins.uo_out[5]), 32'd1);
      chk("start_brw", 32'(pins.uo_out[3]), 32'd0);
      for (int i = 0; i < W; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               bv_i = 1'b0;
               a_i  = 1'($urandom);
               b_i  = 1'($urandom);
               @(negedge clk);
               cyc++;
               chk("gap_dv", 32'(pins.uo_out[1]), 32'd0);
               chk("gap_busy", 32'(pins.uo_out[5]), 32'd1);
            end
         end
         a_i  = a[i];
         b_i  = b[i];
         bv_i = 1'b1;
         @(negedge clk);
         cyc++;
         chk("dv", 32'(pins.uo_out[1]), 32'd1);
         chk("dbit", 32'(pins.uo_out[0]), 32'(diff[i]));
         chk("done", 32'(pins.uo_out[2]), 32'(i == W - 1));
         chk("run_brw", 32'(pins.uo_out[3]), 32'(pre_brw(a, b, i + 1)));
      end
      bv_i = 1'b0;
      chk("uio_out", 32'(pins.uio_out), 32'(diff));
      chk("uio_oe", 32'(pins.uio_oe), 32'hFF);
      chk("borrow", 32'(pins.uo_out[3]), 32'(fb));
      chk("zero", 32'(pins.uo_out[4]), 32'(ez));
      chk("busy_end", 32'(pins.uo_out[5]), 32'd0);
      // DONE holds; bit_valid here must be ignored.
      bv_i = 1'b1;
      a_i  = 1'($urandom);
      b_i  = 1'($urandom);
      @(negedge clk);
      bv_i = 1'b0;
      chk("hold_done", 32'(pins.uo_out[2]), 32'd1);
      chk("hold_dv", 32'(pins.uo_out[1]), 32'd0);
      chk("hold_uio", 32'(pins.uio_out), 32'(diff));
   endtask

   // Start plus n valid bits, leaving the run unfinished.
   task automatic partial(input logic [7:0] a, input logic [7:0] b,
                          input int n);
      @(negedge clk);
      st_i = 1'b1;
      bv_i = 1'b0;
      @(negedge clk);
      st_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         a_i  = a[i];
         b_i  = b[i];
         bv_i = 1'b1;
         @(negedge clk);
      end
   endtask

   vec_t vt[5];

   initial begin
      int cyc;
      int ga;
      int gl;
      logic [7:0] ra;
      logic [7:0] rb;

      vt[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 0, 0};
      vt[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 0, 0};
      vt[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 0, 0};
      vt[3] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 0, 0};
      vt[4] = '{8'h35, 8'h12, 8'h23, 1'b0, 3, 3};

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_uo", 32'(pins.uo_out), 32'h00);
      chk("rst_uio", 32'(pins.uio_out), 32'h00);
      chk("rst_oe", 32'(pins.uio_oe), 32'h00);
      rst_n = 1'b1;

      // bit_valid in IDLE is ignored.
      bv_i = 1'b1;
      a_i  = 1'b0;
      b_i  = 1'b1;
      repeat (2) @(negedge clk);
      bv_i = 1'b0;
      chk("idle_busy", 32'(pins.uo_out[5]), 32'd0);
      chk("idle_dv", 32'(pins.uo_out[1]), 32'd0);

      for (int k = 0; k < 5; k++) begin
         run_op(vt[k].a, vt[k].b, vt[k].gap_at, vt[k].gap_len,
                1'(k == 1), cyc);
         chk("tbl_diff", 32'(pins.uio_out), 32'(vt[k].diff));
         chk("tbl_brw", 32'(pins.uo_out[3]), 32'(vt[k].brw));
         chk("tbl_lat", 32'(cyc), 32'(1 + W + vt[k].gap_len));
      end

      // Abort after 4 bits, restart with start+bit_valid together.
      partial(8'hFF, 8'h00, 4);
      chk("abort_busy", 32'(pins.uo_out[5]), 32'd1);
      run_op(8'h0F, 8'h01, 0, 0, 1'b1, cyc);
      chk("abort_res", 32'(pins.uio_out), 32'h0E);
      chk("abort_lat", 32'(cyc), 32'(1 + W));

      // Asynchronous reset between edges in the middle of a run.
      partial(8'h12, 8'h35, 5);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_uo", 32'(pins.uo_out), 32'h00);
      chk("arst_uio", 32'(pins.uio_out), 32'h00);
      chk("arst_oe", 32'(pins.uio_oe), 32'h00);
      bv_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_idle", 32'(pins.uo_out), 32'h00);
      run_op(8'h35, 8'h12, 0, 0, 1'b0, cyc);
      chk("arst_clean", 32'(pins.uio_out), 32'h23);

      for (int r = 0; r < 20; r++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (r == 0) rb = ra;
         ga = $urandom_range(0, W - 1);
         gl = $urandom_range(0, 3);
         run_op(ra, rb, ga, gl, 1'($urandom), cyc);
         chk("rnd_lat", 32'(cyc), 32'(1 + W + gl));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
